muldiv_sequencer: RTL

- Multi-cycle controller for the RV32M extension, sitting beside the single-cycle ALU in the EX stage.
- Accepts one M-type operation from the ALU-control decode path (funct7 = 0000001, opcode OP).
- Iterates a 32-step shift-add multiplier or restoring divider, and holds the pipeline stalled through `busy` until `result` is ready.
- Returns the result with a one-cycle `done` pulse, which the EX-stage writeback mux selects instead of the ALU output.

---
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/muldiv_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sequencer_if                                    |
// | Description : Request/response bundle between the EX stage and the   |
// |               RV32M multi-cycle multiply/divide sequencer.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface muldiv_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   // EX-stage side: issues operations, observes stall and result
   modport master (
      output start, funct3, op_a, op_b, flush,
      input  busy, done, result
   );

   // Sequencer side
   modport slave (
      input  start, funct3, op_a, op_b, flush,
      output busy, done, result
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sequencer                                       |
// | Description : RV32M controller: 32-step shift-add multiplier and     |
// |               restoring divider with sign fix-up, stall and one-     |
// |               cycle done pulse. Divide-by-zero and signed overflow   |
// |               finish in a single cycle.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module muldiv_sequencer #(
   parameter int XLEN   = 32,
   parameter int ITER_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_sequencer_if.slave  md
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [ITER_W-1:0] LAST_STEP = ITER_W'(XLEN - 1);
   localparam logic [XLEN-1:0]   INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]   ALL_ONES  = {XLEN{1'b1}};

   logic [1:0]        state_q,  state_d;
   logic [ITER_W-1:0] cnt_q,    cnt_d;
   logic [2*XLEN-1:0] acc_q,    acc_d;     // mul: {hi, multiplier}; div: {rem, quo}
   logic [XLEN-1:0]   opnd_q,   opnd_d;    // multiplicand or divisor magnitude
   logic [2:0]        f3_q,     f3_d;
   logic              neg_q,    neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Operand decode at issue time
   logic            w_open, w_accept;
   logic            w_sign_a_en, w_sign_b_en, w_neg_a, w_neg_b, w_negate;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic            w_div0, w_ovf, w_fast;
   logic [XLEN-1:0] w_fast_res;

   // Iteration datapath
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN:0]     w_rem_sh;
   logic              w_rem_ge;
   logic [XLEN-1:0]   w_rem_sub;
   logic [2*XLEN-1:0] w_div_next;

   // Fix-up datapath
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

   assign w_open   = (state_q == S_IDLE) || (state_q == S_DONE);
   assign w_accept = w_open && md.start && !md.flush;

   // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
   assign w_sign_a_en = (md.funct3 == 3'b001) || (md.funct3 == 3'b010) ||
                        (md.funct3[2] && !md.funct3[0]);
   assign w_sign_b_en = (md.funct3 == 3'b001) || (md.funct3[2] && !md.funct3[0]);
   assign w_neg_a     = w_sign_a_en && md.op_a[XLEN-1];
   assign w_neg_b     = w_sign_b_en && md.op_b[XLEN-1];
   assign w_abs_a     = w_neg_a ? -md.op_a : md.op_a;
   assign w_abs_b     = w_neg_b ? -md.op_b : md.op_b;
   // Remainder takes the dividend's sign; product and quotient the XOR
   assign w_negate    = (md.funct3[2] && md.funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

   assign w_div0 = md.funct3[2] && (md.op_b == '0);
   assign w_ovf  = md.funct3[2] && !md.funct3[0] &&
                   (md.op_a == INT_MIN) && (md.op_b == ALL_ONES);
   assign w_fast = w_div0 || w_ovf;

   always_comb begin
      w_fast_res = '0;
      if (w_div0)
         w_fast_res = md.funct3[1] ? md.op_a : ALL_ONES;
      else
         w_fast_res = md.funct3[1] ? '0 : INT_MIN;
   end

   // Multiply step: conditional add into the upper half, then shift right
   assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
   assign w_mul_next = acc_q[0] ? {w_mul_sum, acc_q[XLEN-1:1]}
                                : {1'b0, acc_q[2*XLEN-1:1]};

   // Divide step: shift {rem, quo} left, trial-subtract divisor from rem
   assign w_rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign w_rem_ge   = (w_rem_sh >= {1'b0, opnd_q});
   assign w_rem_sub  = w_rem_sh[XLEN-1:0] - opnd_q;
   assign w_div_next = w_rem_ge ? {w_rem_sub, acc_q[XLEN-2:0], 1'b1}
                                : {acc_q[2*XLEN-2:0], 1'b0};

   assign w_prod = neg_q ? -acc_q : acc_q;
   assign w_quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign w_rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   // Output selection for the fix-up cycle
   always_comb begin
      w_fix_res = '0;
      case (f3_q)
         3'b000:                 w_fix_res = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_res = w_quo;
         default:                w_fix_res = w_rem;
      endcase
   end

   // Sequencer next-state: issue, iterate, fix up, report
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         S_ITER: begin
            if (md.flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = f3_q[2] ? w_div_next : w_mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_STEP)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (md.flush) begin
               state_d = S_IDLE;
            end else begin
               result_d = w_fix_res;
               state_d  = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept a new operation
            if (w_accept) begin
               f3_d  = md.funct3;
               neg_d = w_negate;
               if (w_fast) begin
                  result_d = w_fast_res;
                  state_d  = S_DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_ITER;
                  if (md.funct3[2]) begin
                     acc_d  = {{XLEN{1'b0}}, w_abs_a};
                     opnd_d = w_abs_b;
                  end else begin
                     acc_d  = {{XLEN{1'b0}}, w_abs_b};
                     opnd_d = w_abs_a;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign md.busy   = (state_q == S_ITER) || (state_q == S_FIX) || (w_accept && !w_fast);
   assign md.done   = (state_q == S_DONE);
   assign md.result = result_q;

endmodule
`default_nettype wire
